mod_count_monitor: RTL and testbench
====================================

# mod_count_monitor

Receive-side companion to the team's modulo-N counters (clear-to-zero up counters, preset down counters, preset-offset up counters). It samples a counter value stream, infers counting direction and the [lo, hi] range, locks once the sequence is consistent, then flags every out-of-sequence value. It sits beside any counter under observation, for self-check logic and bench scoreboarding.

## Interface
- W, 4, counter value width
- LOCK_WRAPS, 2, consistent wraps required to assert lock (1..15)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous restart; same effect as rst; priority over cnt_vld
- cnt_in  in  W  observed counter value
- cnt_vld  in  1  cnt_in is a new sample; one sample per counter step
- locked  out  1  sequence tracked and consistent
- dir  out  1  0 = up, 1 = down; valid while locked
- lo  out  W  smallest sequence value; valid while locked
- hi  out  W  largest sequence value; valid while locked
- modulus  out  W+1  hi - lo + 1; valid while locked
- wrap_pulse  out  1  one-cycle pulse per accepted consistent wrap
- err_pulse  out  1  one-cycle pulse per sequence error while locked
- err_cnt  out  8  saturating error count (holds at 255)

## Operation
- Step rules, compared in W+1 bits (no modulo-2^W): up-step: new == prev+1; down-step: prev != 0 and new == prev-1; up-wrap: new < prev; down-wrap: new > prev.
- States: IDLE, DIR, TRACK, VERIFY, LOCKED. All state changes occur only on accepted samples (cnt_vld = 1).
- IDLE: first sample is stored as prev -> DIR.
- DIR: up-step -> dir=0, TRACK; down-step -> dir=1, TRACK. Any other sample, including equal values and wraps, becomes the new prev and the block stays in DIR.
- TRACK: a step in dir stays in TRACK. A wrap in dir captures the range: for up, hi=prev and lo=new; for down, hi=new and lo=prev. It then sets wraps=1 and goes to VERIFY (or LOCKED if LOCK_WRAPS==1). Any other sample -> DIR with the sample as prev, no error.
- Expected next: up gives prev==hi ? lo : prev+1; down gives prev==lo ? hi : prev-1.
- VERIFY: a sample equal to expected is accepted. An accepted wrap increments wraps; when wraps reaches LOCK_WRAPS the block goes to LOCKED. A mismatch goes to DIR silently, with no err_pulse and no err_cnt change.
- LOCKED: a match is accepted. A mismatch asserts err_pulse, increments err_cnt (saturating), deasserts locked, and goes to DIR with the offending sample as prev.
- wrap_pulse fires on every accepted consistent wrap in VERIFY and LOCKED, including the wrap that enters LOCKED. It also fires for the capturing wrap in TRACK.
- A constant (modulus-1) counter never locks. Modulus range is 2..2^W.
- lo/hi/dir/modulus hold their last captured values after lock loss until the next capture.

## Timing
- Reset/clr values: locked=0, dir=0, lo=0, hi=0, modulus=0, wrap_pulse=0, err_pulse=0, err_cnt=0, state IDLE.
- All outputs are registered. Response comes one cycle after the accepting edge.
- locked rises on the cycle after the edge that accepts the LOCK_WRAPS-th wrap. It falls on the cycle after the edge that accepts an erroneous sample, together with err_pulse.
- Back-to-back cnt_vld on every cycle is supported. Gaps between samples are ignored, with no timeout.
- rst mid-sequence clears everything immediately. clr asserted together with cnt_vld discards the sample.
- err_cnt at 255 stays at 255, while err_pulse still fires.

## Test plan
- Up 0..10 from reset, LOCK_WRAPS=2, feed 0,1..10,0..10,0 -> wrap_pulse after each 10->0 step; locked=1 after the second wrap; lo=0, hi=10, modulus=11, dir=0.
- Down 10..0, starting mid-sequence at 6 -> dir=1, lo=0, hi=10, modulus=11, locked after 2 wraps, err_cnt=0.
- Up preset 5..15, plus full range 0..15 in a separate run -> modulus=11 (lo=5, hi=15) and modulus=16 (lo=0, hi=15) respectively.
- While locked on 0..10, feed 3 where 4 is expected -> err_pulse one cycle, err_cnt=1, locked=0; relock after 2 further clean wraps.
- Pre-lock glitch (0,1,2,7,8,...) -> no err_pulse, err_cnt=0, lock is achieved later. Force 256 errors -> err_cnt=255.
- Assert rst, and separately clr together with cnt_vld, while locked -> all outputs return to reset values; the clr-cycle sample is not used.

Source files
------------

// File: rtl/mod_count_monitor_if.sv
// Sample/status bundle between an observed counter's tap point and
// the modulo-counter sequence monitor.
interface mod_count_monitor_if #(
   parameter int W = 4
);
   logic         clr;
   logic [W-1:0] cnt_in;
   logic         cnt_vld;
   logic         locked;
   logic         dir;
   logic [W-1:0] lo;
   logic [W-1:0] hi;
   logic [W:0]   modulus;
   logic         wrap_pulse;
   logic         err_pulse;
   logic [7:0]   err_cnt;

   modport master (
      output clr,
      output cnt_in,
      output cnt_vld,
      input  locked,
      input  dir,
      input  lo,
      input  hi,
      input  modulus,
      input  wrap_pulse,
      input  err_pulse,
      input  err_cnt
   );

   modport slave (
      input  clr,
      input  cnt_in,
      input  cnt_vld,
      output locked,
      output dir,
      output lo,
      output hi,
      output modulus,
      output wrap_pulse,
      output err_pulse,
      output err_cnt
   );
endinterface

// File: rtl/mod_count_monitor.sv
// Infers direction and [lo,hi] of a modulo-N counter stream, locks
// after LOCK_WRAPS consistent wraps, then flags out-of-sequence values.
module mod_count_monitor #(
   parameter int W          = 4,
   parameter int LOCK_WRAPS = 2
) (
   input logic                clk,
   input logic                rst,
   mod_count_monitor_if.slave bus
);
   localparam logic [W-1:0] ONE   = W'(1);
   localparam logic [W:0]   ONE_X = (W+1)'(1);
   localparam logic [3:0]   LW    = 4'(LOCK_WRAPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIR,
      S_TRACK,
      S_VERIFY,
      S_LOCKED
   } state_t;

   state_t       r_state, w_state_nx;
   logic [W-1:0] r_prev, w_prev_nx;
   logic         r_tdir, w_tdir_nx;
   logic         r_dir, w_dir_nx;
   logic [W-1:0] r_lo, w_lo_nx;
   logic [W-1:0] r_hi, w_hi_nx;
   logic [W:0]   r_mod, w_mod_nx;
   logic [3:0]   r_wraps, w_wraps_nx;
   logic         r_locked, w_locked_nx;
   logic         r_wrap_p, w_wrap_p_nx;
   logic         r_err_p, w_err_p_nx;
   logic [7:0]   r_err_cnt, w_err_cnt_nx;

   logic [W:0]   w_new, w_prv;
   logic         w_up_step, w_dn_step;
   logic         w_up_wrap, w_dn_wrap;
   logic         w_step, w_wrap;
   logic [W-1:0] w_cap_lo, w_cap_hi;
   logic [W:0]   w_cap_mod;
   logic         w_at_end;
   logic [W-1:0] w_expect;
   logic         w_match;
   logic [3:0]   w_wraps_inc;
   logic [7:0]   w_err_sat;

   // Step/wrap tests are done one bit wider so nothing aliases mod 2^W
   assign w_new     = {1'b0, bus.cnt_in};
   assign w_prv     = {1'b0, r_prev};
   assign w_up_step = (w_new == w_prv + ONE_X);
   assign w_dn_step = (|r_prev) && (w_new == w_prv - ONE_X);
   assign w_up_wrap = (w_new < w_prv);
   assign w_dn_wrap = (w_new > w_prv);
   assign w_step    = r_tdir ? w_dn_step : w_up_step;
   assign w_wrap    = r_tdir ? w_dn_wrap : w_up_wrap;

   assign w_cap_lo  = r_tdir ? r_prev : bus.cnt_in;
   assign w_cap_hi  = r_tdir ? bus.cnt_in : r_prev;
   assign w_cap_mod = {1'b0, w_cap_hi} - {1'b0, w_cap_lo} + ONE_X;

   assign w_at_end  = r_dir ? (r_prev == r_lo) : (r_prev == r_hi);
   assign w_expect  = r_dir ? (w_at_end ? r_hi : r_prev - ONE)
                            : (w_at_end ? r_lo : r_prev + ONE);
   assign w_match   = (bus.cnt_in == w_expect);

   assign w_wraps_inc = r_wraps + 4'd1;
   assign w_err_sat   = (r_err_cnt == 8'hFF) ? r_err_cnt
                                             : r_err_cnt + 8'd1;

   always_comb begin
      w_state_nx   = r_state;
      w_prev_nx    = r_prev;
      w_tdir_nx    = r_tdir;
      w_dir_nx     = r_dir;
      w_lo_nx      = r_lo;
      w_hi_nx      = r_hi;
      w_mod_nx     = r_mod;
      w_wraps_nx   = r_wraps;
      w_locked_nx  = r_locked;
      w_wrap_p_nx  = 1'b0;
      w_err_p_nx   = 1'b0;
      w_err_cnt_nx = r_err_cnt;
      if (bus.clr) begin
         w_state_nx   = S_IDLE;
         w_prev_nx    = '0;
         w_tdir_nx    = 1'b0;
         w_dir_nx     = 1'b0;
         w_lo_nx      = '0;
         w_hi_nx      = '0;
         w_mod_nx     = '0;
         w_wraps_nx   = '0;
         w_locked_nx  = 1'b0;
         w_err_cnt_nx = '0;
      end else if (bus.cnt_vld) begin
         w_prev_nx = bus.cnt_in;
         unique case (r_state)
            S_IDLE: begin
               w_state_nx = S_DIR;
            end
            S_DIR: begin
               if (w_up_step) begin
                  w_tdir_nx  = 1'b0;
                  w_state_nx = S_TRACK;
               end else if (w_dn_step) begin
                  w_tdir_nx  = 1'b1;
                  w_state_nx = S_TRACK;
               end
            end
            S_TRACK: begin
               if (w_step) begin
                  w_state_nx = S_TRACK;
               end else if (w_wrap) begin
                  w_dir_nx    = r_tdir;
                  w_lo_nx     = w_cap_lo;
                  w_hi_nx     = w_cap_hi;
                  w_mod_nx    = w_cap_mod;
                  w_wraps_nx  = 4'd1;
                  w_wrap_p_nx = 1'b1;
                  if (LW == 4'd1) begin
                     w_locked_nx = 1'b1;
                     w_state_nx  = S_LOCKED;
                  end else begin
                     w_state_nx  = S_VERIFY;
                  end
               end else begin
                  w_state_nx = S_DIR;
               end
            end
            S_VERIFY: begin
               if (!w_match) begin
                  w_state_nx = S_DIR;
               end else if (w_at_end) begin
                  w_wrap_p_nx = 1'b1;
                  w_wraps_nx  = w_wraps_inc;
                  if (w_wraps_inc == LW) begin
                     w_locked_nx = 1'b1;
                     w_state_nx  = S_LOCKED;
                  end
               end
            end
            S_LOCKED: begin
               if (!w_match) begin
                  w_err_p_nx   = 1'b1;
                  w_err_cnt_nx = w_err_sat;
                  w_locked_nx  = 1'b0;
                  w_state_nx   = S_DIR;
               end else if (w_at_end) begin
                  w_wrap_p_nx = 1'b1;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_prev    <= '0;
         r_tdir    <= 1'b0;
         r_dir     <= 1'b0;
         r_lo      <= '0;
         r_hi      <= '0;
         r_mod     <= '0;
         r_wraps   <= '0;
         r_locked  <= 1'b0;
         r_wrap_p  <= 1'b0;
         r_err_p   <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_prev    <= w_prev_nx;
         r_tdir    <= w_tdir_nx;
         r_dir     <= w_dir_nx;
         r_lo      <= w_lo_nx;
         r_hi      <= w_hi_nx;
         r_mod     <= w_mod_nx;
         r_wraps   <= w_wraps_nx;
         r_locked  <= w_locked_nx;
         r_wrap_p  <= w_wrap_p_nx;
         r_err_p   <= w_err_p_nx;
         r_err_cnt <= w_err_cnt_nx;
      end
   end

   assign bus.locked     = r_locked;
   assign bus.dir        = r_dir;
   assign bus.lo         = r_lo;
   assign bus.hi         = r_hi;
   assign bus.modulus    = r_mod;
   assign bus.wrap_pulse = r_wrap_p;
   assign bus.err_pulse  = r_err_p;
   assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_mod_count_monitor.sv
// Randomized and directed checks of mod_count_monitor against a
// behavioural sequence model using modular arithmetic.
module tb_mod_count_monitor;
   localparam int W  = 4;
   localparam int LW = 2;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   mod_count_monitor_if #(.W(W)) bus();

   mod_count_monitor #(.W(W), .LOCK_WRAPS(LW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model phases: waiting, seeking direction, running, confirming, locked
   localparam int P_WAIT = 0, P_SEEK = 1, P_RUN = 2, P_CONF = 3, P_LOCK = 4;
   int m_ph, m_prev, m_tdir, m_wraps;
   int m_locked, m_dir, m_lo, m_hi, m_mod;
   int m_wrap, m_err, m_ecnt;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ph = P_WAIT; m_prev = 0; m_tdir = 0; m_wraps = 0;
      m_locked = 0; m_dir = 0; m_lo = 0; m_hi = 0; m_mod = 0;
      m_wrap = 0; m_err = 0; m_ecnt = 0;
   endtask

   task automatic m_sample(input int v);
      int off, e;
      bit st, wr;
      case (m_ph)
         P_WAIT: m_ph = P_SEEK;
         P_SEEK: begin
            if (v == m_prev + 1) begin m_tdir = 0; m_ph = P_RUN; end
            else if (m_prev > 0 && v == m_prev - 1) begin
               m_tdir = 1; m_ph = P_RUN;
            end
         end
         P_RUN: begin
            st = m_tdir ? (m_prev > 0 && v == m_prev - 1) : (v == m_prev + 1);
            wr = m_tdir ? (v > m_prev) : (v < m_prev);
            if (!st && wr) begin
               m_dir = m_tdir;
               m_lo  = m_tdir ? m_prev : v;
               m_hi  = m_tdir ? v : m_prev;
               m_mod = m_hi - m_lo + 1;
               m_wraps = 1; m_wrap = 1;
               if (LW == 1) begin m_ph = P_LOCK; m_locked = 1; end
               else m_ph = P_CONF;
            end else if (!st) m_ph = P_SEEK;
         end
         default: begin
            off = m_prev - m_lo;
            e = m_lo + (m_dir ? (off + m_mod - 1) % m_mod : (off + 1) % m_mod);
            if (v == e) begin
               if (m_dir ? off == 0 : off == m_mod - 1) begin
                  m_wrap = 1;
                  if (m_ph == P_CONF) begin
                     m_wraps++;
                     if (m_wraps == LW) begin m_ph = P_LOCK; m_locked = 1; end
                  end
               end
            end else begin
               if (m_ph == P_LOCK) begin
                  m_err = 1; m_locked = 0;
                  if (m_ecnt < 255) m_ecnt++;
               end
               m_ph = P_SEEK;
            end
         end
      endcase
      m_prev = v;
   endtask

   task automatic check_all();
      chk("locked", int'(bus.locked), m_locked);
      chk("dir", int'(bus.dir), m_dir);
      chk("lo", int'(bus.lo), m_lo);
      chk("hi", int'(bus.hi), m_hi);
      chk("modulus", int'(bus.modulus), m_mod);
      chk("wrap_pulse", int'(bus.wrap_pulse), m_wrap);
      chk("err_pulse", int'(bus.err_pulse), m_err);
      chk("err_cnt", int'(bus.err_cnt), m_ecnt);
   endtask

   task automatic cyc(input bit vld, input int v, input bit c);
      @(negedge clk);
      bus.cnt_vld = vld;
      bus.cnt_in  = W'(v);
      bus.clr     = c;
      @(posedge clk);
      if (c) m_reset();
      else begin
         m_wrap = 0; m_err = 0;
         if (vld) m_sample(v);
      end
      #1;
      check_all();
   endtask

   task automatic run(input int lo, input int hi, input int d,
                      input int start, input int n);
      int c;
      c = start;
      for (int k = 0; k < n; k++) begin
         cyc(1, c, 0);
         if (d == 0) c = (c == hi) ? lo : c + 1;
         else        c = (c == lo) ? hi : c - 1;
      end
   endtask

   task automatic chk_range(input string tag, input int d,
                            input int lo, input int hi, input int md);
      chk({tag, ".locked"}, int'(bus.locked), 1);
      chk({tag, ".dir"}, int'(bus.dir), d);
      chk({tag, ".lo"}, int'(bus.lo), lo);
      chk({tag, ".hi"}, int'(bus.hi), hi);
      chk({tag, ".mod"}, int'(bus.modulus), md);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      m_reset();
      rst = 1'b1;
      bus.clr = 1'b0; bus.cnt_vld = 1'b0; bus.cnt_in = '0;
      #12;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // up 0..10 from reset
      run(0, 10, 0, 0, 23);
      chk_range("up10", 0, 0, 10, 11);

      // error while locked: 3 where 4 is expected
      run(0, 10, 0, 1, 3);
      cyc(1, 3, 0);
      chk("err.pulse", int'(bus.err_pulse), 1);
      chk("err.cnt", int'(bus.err_cnt), 1);
      chk("err.locked", int'(bus.locked), 0);
      run(0, 10, 0, 4, 19);
      chk("relock", int'(bus.locked), 1);

      // down 10..0 starting mid-sequence
      cyc(0, 0, 1);
      run(0, 10, 1, 6, 19);
      chk_range("down10", 1, 0, 10, 11);
      chk("down.errs", int'(bus.err_cnt), 0);

      cyc(0, 0, 1);
      run(5, 15, 0, 5, 23);
      chk_range("pre5", 0, 5, 15, 11);

      cyc(0, 0, 1);
      run(0, 15, 0, 0, 33);
      chk_range("full", 0, 0, 15, 16);

      // pre-lock glitch
      cyc(0, 0, 1);
      cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 2, 0);
      cyc(1, 7, 0); cyc(1, 8, 0);
      run(0, 10, 0, 9, 14);
      chk("glitch.lock", int'(bus.locked), 1);
      chk("glitch.errs", int'(bus.err_cnt), 0);

      // constant counter
      cyc(0, 0, 1);
      for (int k = 0; k < 30; k++) cyc(1, 7, 0);
      chk("const.lock", int'(bus.locked), 0);

      // randomized counters with gaps, glitches and restarts
      for (int r = 0; r < 60; r++) begin
         int lo, hi, d, c, len;
         lo  = $urandom_range(0, 14);
         hi  = $urandom_range(lo + 1, 15);
         if ($urandom_range(0, 9) == 0) hi = lo;
         d   = $urandom_range(0, 1);
         c   = $urandom_range(lo, hi);
         len = $urandom_range(20, 60);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 4) == 0) cyc(0, $urandom_range(0, 15), 0);
            if ($urandom_range(0, 149) == 0)
               cyc(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1);
            if ($urandom_range(0, 39) == 0) cyc(1, $urandom_range(0, 15), 0);
            else cyc(1, c, 0);
            if (d == 0) c = (c == hi) ? lo : c + 1;
            else        c = (c == lo) ? hi : c - 1;
         end
      end

      // saturation of the error counter
      cyc(0, 0, 1);
      run(0, 2, 0, 0, 7);
      for (int k = 0; k < 260; k++) begin
         cyc(1, 0, 0);
         run(0, 2, 0, 1, 6);
      end
      chk("sat.cnt", int'(bus.err_cnt), 255);
      cyc(1, 0, 0);
      chk("sat.pulse", int'(bus.err_pulse), 1);
      chk("sat.hold", int'(bus.err_cnt), 255);
      run(0, 2, 0, 1, 6);

      // asynchronous reset while locked
      chk("pre_rst.lock", int'(bus.locked), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      m_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // clr together with cnt_vld while locked
      run(0, 10, 0, 0, 23);
      chk("pre_clr.lock", int'(bus.locked), 1);
      cyc(1, 1, 1);
      chk("clr.cnt", int'(bus.err_cnt), 0);
      chk("clr.lock", int'(bus.locked), 0);
      run(0, 10, 0, 2, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
